// File: rtl/vector_recorder_pkg.sv
// Shared types and defaults for the vector recorder: FSM state encoding,
// default geometry and pointer-width helper.
package vector_recorder_pkg;

  localparam int unsigned VEC_W_DEF = 4;
  localparam int unsigned DEPTH_DEF = 16;

  // Encodings are pinned so captured state values match the legacy block.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DUMP   = 2'd2
  } state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/vector_recorder_if.sv
// Capture/readback bundle of the vector recorder. The master side is the
// environment (control, samples, consumer); the slave side is the recorder.
interface vector_recorder_if
  import vector_recorder_pkg::*;
#(
  parameter int unsigned VEC_W = VEC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
);

  logic                    start;
  logic                    stop;
  logic                    sample_valid;
  logic [VEC_W-1:0]        sample_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [VEC_W-1:0]        rd_data;
  logic                    rd_last;
  logic                    busy;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;

  modport master (
    output start, stop, sample_valid, sample_data, rd_ready,
    input  rd_valid, rd_data, rd_last, busy, full, count, overflow
  );

  modport slave (
    input  start, stop, sample_valid, sample_data, rd_ready,
    output rd_valid, rd_data, rd_last, busy, full, count, overflow
  );

endinterface

// File: rtl/vector_recorder_mem.sv
// Vector storage: DEPTH x VEC_W registers, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module vector_mem
  import vector_recorder_pkg::*;
#(
  parameter int unsigned VEC_W = VEC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [VEC_W-1:0]        wdata_i,
  input  logic [ptr_w(DEPTH)-1:0] raddr_i,
  output logic [VEC_W-1:0]        rdata_o
);

  logic [VEC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_recorder.sv
// Vector recorder top: captures sample vectors while armed, then streams them
// back oldest-first over a valid/ready port with a last marker.
module vector_recorder
  import vector_recorder_pkg::*;
#(
  parameter int unsigned VEC_W = VEC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  vector_recorder_if.slave  bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             wr_en;
  logic [PW:0]      count_wr;
  logic             full;
  logic             in_dump;
  logic             last;
  logic [VEC_W-1:0] mem_rdata;

  assign full    = (count_q == DEPTH_C);
  assign in_dump = (state_q == DUMP);
  assign last    = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

  vector_mem #(
    .VEC_W (VEC_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.sample_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    count_wr   = count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RECORD;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end

      RECORD: begin
        if (bus.sample_valid) begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            count_wr = count_q + 1'b1;
            // Hold the write pointer on the final slot so it never wraps.
            if (count_wr != DEPTH_C) begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        count_d = count_wr;
        // Stop sees the post-write count, so a same-cycle sample is kept.
        if (count_wr == DEPTH_C) begin
          state_d = DUMP;
        end else if (bus.stop) begin
          state_d = (count_wr != '0) ? DUMP : IDLE;
        end
      end

      DUMP: begin
        if (bus.sample_valid) begin
          overflow_d = 1'b1;
        end
        if (bus.rd_ready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Read-side outputs decode registered state only; no path from rd_ready.
  assign bus.busy     = (state_q != IDLE);
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_valid = in_dump;
  assign bus.rd_last  = in_dump & last;
  assign bus.rd_data  = in_dump ? mem_rdata : '0;

endmodule
